// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit and the mult/div unit.
// Master issues start pulses with operands; slave returns HI/LO and status.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start_mult, start_div, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start_mult, start_div, a, b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int DW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             rem_ge;
  logic [DW-1:0]    prod;

  // opd_q holds the multiplicand (mult) or the divisor (div) magnitude
  always_comb begin
    mag_a   = bus.a[WIDTH-1] ? -bus.a : bus.a;
    mag_b   = bus.b[WIDTH-1] ? -bus.b : bus.b;
    add_sum = {1'b0, acc_q[DW-1:WIDTH]}
            + {1'b0, opd_q & {WIDTH{acc_q[0]}}};
    rem_sh  = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, opd_q};
    rem_ge  = rem_q[WIDTH] | (rem_sh >= {1'b0, opd_q});
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opd_d     = opd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    prod      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_mult) begin
          state_d   = S_MULT;
          cnt_d     = '0;
          acc_d     = {{WIDTH{1'b0}}, mag_b};
          opd_d     = mag_a;
          neg_res_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          neg_rem_d = bus.a[WIDTH-1];
        end else if (bus.start_div) begin
          cnt_d     = '0;
          acc_d     = {{WIDTH{1'b0}}, mag_a};
          rem_d     = '0;
          opd_d     = mag_b;
          neg_res_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          neg_rem_d = bus.a[WIDTH-1];
          if (bus.b == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MULT: begin
        acc_d = {add_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          prod    = neg_res_q ? -acc_d : acc_d;
          hi_d    = prod[DW-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
        end
      end
      S_DIV: begin
        rem_d = rem_ge ? rem_sub : rem_sh;
        acc_d = {acc_q[DW-1:WIDTH], acc_q[WIDTH-2:0], rem_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          lo_d    = neg_res_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
          hi_d    = neg_rem_q ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opd_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opd_q     <= opd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vectors plus random ops
// against an arithmetic model of signed mult/div with HI/LO.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus ();
  mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [31:0] mhi, mlo;
  logic [31:0] o_hi, o_lo;
  logic        o_dz, o_busy_done, o_busy_after, o_done_after;
  int          o_lat;

  function automatic bit model(input bit is_div, input logic [31:0] a, b);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      p = sa * sb;
      mhi = p[63:32];
      mlo = p[31:0];
      return 1'b0;
    end
    if (b == 32'd0) return 1'b1;
    q = sa / sb;
    r = sa % sb;
    mlo = q[31:0];
    mhi = r[31:0];
    return 1'b0;
  endfunction

  task automatic run_op(input bit is_div, input logic [31:0] ia, ib);
    @(negedge clk);
    bus.a = ia;
    bus.b = ib;
    bus.start_mult = !is_div;
    bus.start_div = is_div;
    @(posedge clk); #1;
    bus.start_mult = 1'b0;
    bus.start_div = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    o_lat = 0;
    while (bus.done !== 1'b1 && o_lat < 100) begin
      @(posedge clk); #1;
      o_lat++;
    end
    o_hi = bus.hi;
    o_lo = bus.lo;
    o_dz = bus.div_zero;
    o_busy_done = bus.busy;
    @(posedge clk); #1;
    o_busy_after = bus.busy;
    o_done_after = bus.done;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start_mult = 1'b0;
    bus.start_div = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
    if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b exp 0", bus.div_zero); end
    @(negedge clk);
    reset = 1'b1;
    mhi = '0;
    mlo = '0;
  endtask

  task automatic test_directed();
    logic [32:0] va[8];
    logic [31:0] vb[8], ehi[8], elo[8];
    va  = '{{1'b0, 32'd7}, {1'b0, 32'h80000000}, {1'b0, 32'd3}, {1'b0, 32'h0000FFFF},
            {1'b1, 32'hFFFFFFF9}, {1'b1, 32'h80000000}, {1'b1, 32'd100}, {1'b1, 32'd7}};
    vb  = '{32'hFFFFFFFD, 32'h80000000, 32'd5, 32'h0000FFFF,
            32'd2, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9};
    ehi = '{32'hFFFFFFFF, 32'h40000000, 32'd0, 32'd0,
            32'hFFFFFFFF, 32'd0, 32'd2, 32'd0};
    elo = '{32'hFFFFFFEB, 32'd0, 32'd15, 32'hFFFE0001,
            32'hFFFFFFFD, 32'h80000000, 32'd14, 32'hFFFFFFFF};
    for (int i = 0; i < 8; i++) begin
      void'(model(va[i][32], va[i][31:0], vb[i]));
      run_op(va[i][32], va[i][31:0], vb[i]);
      checks += 6;
      if (o_hi !== ehi[i]) begin errors++; $display("FAIL dir%0d_hi got %h exp %h", i, o_hi, ehi[i]); end
      if (o_lo !== elo[i]) begin errors++; $display("FAIL dir%0d_lo got %h exp %h", i, o_lo, elo[i]); end
      if (o_lat !== 32) begin errors++; $display("FAIL dir%0d_latency got %0d exp 32", i, o_lat); end
      if (o_dz !== 1'b0) begin errors++; $display("FAIL dir%0d_dz got %b exp 0", i, o_dz); end
      if (o_busy_done !== 1'b1) begin errors++; $display("FAIL dir%0d_busy_at_done got %b exp 1", i, o_busy_done); end
      if ({o_busy_after, o_done_after} !== 2'b00) begin
        errors++;
        $display("FAIL dir%0d_after busy/done got %b%b exp 00", i, o_busy_after, o_done_after);
      end
    end
  endtask

  task automatic test_div_zero();
    run_op(1'b0, 32'd3, 32'd5);
    checks += 2;
    if (o_hi !== 32'd0) begin errors++; $display("FAIL dz_pre_hi got %h exp 0", o_hi); end
    if (o_lo !== 32'd15) begin errors++; $display("FAIL dz_pre_lo got %h exp f", o_lo); end
    run_op(1'b1, 32'd10, 32'd0);
    checks += 6;
    if (o_lat !== 0) begin errors++; $display("FAIL dz_latency got %0d exp 0", o_lat); end
    if (o_dz !== 1'b1) begin errors++; $display("FAIL dz_flag got %b exp 1", o_dz); end
    if (o_hi !== 32'd0) begin errors++; $display("FAIL dz_hi got %h exp 0", o_hi); end
    if (o_lo !== 32'd15) begin errors++; $display("FAIL dz_lo got %h exp f", o_lo); end
    if (o_busy_done !== 1'b1) begin errors++; $display("FAIL dz_busy got %b exp 1", o_busy_done); end
    if ({o_busy_after, o_done_after} !== 2'b00) begin
      errors++;
      $display("FAIL dz_after busy/done got %b%b exp 00", o_busy_after, o_done_after);
    end
    mhi = 32'd0;
    mlo = 32'd15;
  endtask

  task automatic test_busy_ignore();
    int dones, lat;
    logic [31:0] ghi, glo;
    dones = 0;
    lat = -1;
    ghi = '0;
    glo = '0;
    void'(model(1'b0, 32'h00012345, 32'hFFFF0001));
    @(negedge clk);
    bus.a = 32'h00012345;
    bus.b = 32'hFFFF0001;
    bus.start_mult = 1'b1;
    @(posedge clk); #1;
    bus.start_mult = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c == 5) begin bus.start_div = 1'b1; bus.a = 32'd99; bus.b = 32'd4; end
      if (c == 6) begin bus.start_div = 1'b0; bus.start_mult = 1'b1; end
      if (c == 7) bus.start_mult = 1'b0;
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        dones++;
        lat = c;
        ghi = bus.hi;
        glo = bus.lo;
      end
    end
    checks += 4;
    if (dones !== 1) begin errors++; $display("FAIL busy_ign_dones got %0d exp 1", dones); end
    if (lat !== 31) begin errors++; $display("FAIL busy_ign_latency got %0d exp 31", lat); end
    if (ghi !== mhi) begin errors++; $display("FAIL busy_ign_hi got %h exp %h", ghi, mhi); end
    if (glo !== mlo) begin errors++; $display("FAIL busy_ign_lo got %h exp %h", glo, mlo); end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    @(negedge clk);
    bus.a = 32'd1000;
    bus.b = 32'd3;
    bus.start_div = 1'b1;
    @(posedge clk); #1;
    bus.start_div = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks += 4;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", bus.busy); end
    if (bus.hi !== 32'd0) begin errors++; $display("FAIL rst_mid_hi got %h exp 0", bus.hi); end
    if (bus.lo !== 32'd0) begin errors++; $display("FAIL rst_mid_lo got %h exp 0", bus.lo); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", bus.done); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL rst_mid_activity got %0d exp 0", dones); end
    mhi = '0;
    mlo = '0;
  endtask

  task automatic test_random();
    bit is_div, edz;
    logic [31:0] ra, rb;
    int sel;
    for (int i = 0; i < 30; i++) begin
      is_div = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) rb = 32'hFFFFFFFF;
      if (sel == 2) ra = 32'h80000000;
      if (sel == 3) rb = 32'(ra[7:0]);
      edz = model(is_div, ra, rb);
      run_op(is_div, ra, rb);
      checks += 4;
      if (o_hi !== mhi) begin errors++; $display("FAIL rnd%0d_hi op=%b a=%h b=%h got %h exp %h", i, is_div, ra, rb, o_hi, mhi); end
      if (o_lo !== mlo) begin errors++; $display("FAIL rnd%0d_lo op=%b a=%h b=%h got %h exp %h", i, is_div, ra, rb, o_lo, mlo); end
      if (o_dz !== edz) begin errors++; $display("FAIL rnd%0d_dz got %b exp %b", i, o_dz, edz); end
      if (o_lat !== (edz ? 0 : 32)) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, o_lat, edz ? 0 : 32); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ba[3], bb[3];
    ba = '{32'hFFFFFF00, 32'd12345, 32'h7FFFFFFF};
    bb = '{32'd13, 32'hFFFFFF85, 32'h7FFFFFFF};
    for (int i = 0; i < 3; i++) begin
      void'(model(i != 2, ba[i], bb[i]));
      run_op(i != 2, ba[i], bb[i]);
      checks += 3;
      if (o_lat !== 32) begin errors++; $display("FAIL b2b%0d_latency got %0d exp 32", i, o_lat); end
      if (o_hi !== mhi) begin errors++; $display("FAIL b2b%0d_hi got %h exp %h", i, o_hi, mhi); end
      if (o_lo !== mlo) begin errors++; $display("FAIL b2b%0d_lo got %h exp %h", i, o_lo, mlo); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
